cp0_unit: RTL and testbench
===========================

# cp0_unit

Parametrised MIPS coprocessor-0 for the 5-stage core, successor to the fixed single-configuration CP0. It holds BadVAddr, Count, Compare, Status, Cause, EPC, PRId and Config, and serves MFC0/MTC0 from the pipeline. It takes one exception or ERET per cycle from the memory stage and drives the pipeline flush and redirect PC. It adds a configurable hardware-interrupt count, a Count prescaler, BadVAddr capture and ERET/flush generation.

## Interface
- HW_INT_NUM, 6, number of hardware interrupt lines (1..6), mapped to Cause.IP[2+HW_INT_NUM-1:2]
- COUNT_DIV, 2, Count increments once every COUNT_DIV cycles (1 or 2)
- PRID_VAL, 32'h004C_0102, constant PRId value
- EXC_VECTOR, 32'hBFC0_0380, redirect PC on any exception
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- mtc0_we_i  in  1  MTC0 write enable
- mtc0_addr_i  in  5  MTC0 register number
- mtc0_data_i  in  32  MTC0 data
- mfc0_addr_i  in  5  MFC0 register number
- mfc0_data_o  out  32  MFC0 read data (combinational)
- hw_int_i  in  HW_INT_NUM  level-sensitive hardware interrupts
- exc_valid_i  in  1  exception commit this cycle
- exc_code_i  in  5  ExcCode (0 = Int, 4 = AdEL, 5 = AdES, 8 = Sys, 9 = Bp, 10 = RI, 12 = Ov)
- exc_pc_i  in  32  PC of the faulting instruction
- exc_bd_i  in  1  faulting instruction is in a delay slot
- exc_badvaddr_i  in  32  faulting address (AdEL/AdES)
- eret_i  in  1  ERET commit this cycle
- flush_o  out  1  pipeline flush (combinational: exc_valid_i | eret_i)
- flush_pc_o  out  32  EXC_VECTOR on exception, else EPC
- int_pending_o  out  1  Status.IE & ~Status.EXL & |(Cause.IP & Status.IM)
- status_o, cause_o, epc_o  out  32 each  register mirrors

## Operation
- Register numbers: 8 BadVAddr, 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC, 15 PRId, 16 Config. Unmapped registers read 0; writes to them are ignored.
- MFC0 returns the registered value. There is no bypass of a same-cycle MTC0.
- Status writable bits: IM[15:8], EXL[1], IE[0]. BEV[22] is constant 1. All other bits read 0.
- Cause fields:
  - BD[31] and ExcCode[6:2] are written by exceptions only.
  - TI[30] and IP7 are driven by the timer latch, OR'd with hw_int_i[5] into IP7 when HW_INT_NUM = 6.
  - IP[1:0] are software-writable.
  - IP[2+k] is a registered copy of hw_int_i[k], sampled every cycle. Unimplemented IP bits read 0.
- Config reads 32'h0000_8000 and is read-only.
- Exception (exc_valid_i):
  - ExcCode <= exc_code_i; EXL <= 1.
  - If EXL was 0: EPC <= exc_bd_i ? exc_pc_i-4 : exc_pc_i, and BD <= exc_bd_i.
  - If EXL was already 1: EPC and BD hold.
  - For codes 4/5: BadVAddr <= exc_badvaddr_i.
- ERET: EXL <= 0. flush_pc_o = EPC.
- Timer:
  - A prescaler phase counter produces a tick every COUNT_DIV cycles; Count += 1 on each tick and wraps 0xFFFF_FFFF -> 0.
  - TI sets when a tick advances Count to a value equal to Compare.
  - TI holds until an MTC0 to Compare.
- Same-cycle priority, highest first: rst > exc_valid_i > eret_i > MTC0.
  - If exc_valid_i and eret_i are both high, ERET is ignored.
  - An MTC0 in the same cycle as an exception or ERET is still applied to registers those events do not touch.
- MTC0 Count overrides that cycle's increment and clears the prescaler phase.
- MTC0 Compare clears TI, overriding a same-cycle match.

## Timing
- Reset values: Count 0, Compare 0, Status 32'h0040_0000, Cause 0, EPC 0, BadVAddr 0, TI 0, prescaler phase 0.
- While rst is high: mfc0_data_o = 0 and int_pending_o = 0.
- Writes take effect at the next edge and are visible to MFC0 one cycle after the write.
- hw_int_i -> Cause.IP -> int_pending_o: 1 cycle.
- TI visible one cycle after the matching tick edge.
- flush_o and flush_pc_o: 0 cycles (combinational), using the pre-update EPC.

## Configuration
- CP0_TIMER_EN defined: Count, Compare, prescaler and TI are present as described above.
- CP0_TIMER_EN undefined:
  - Count and Compare read 0 and writes to them are ignored.
  - TI is constant 0; IP7 carries hw_int_i[5] only, when present.
  - The prescaler is removed.

## Structure
- Package cp0_pkg holds:
  - register-number constants (CP0_REG_*)
  - ExcCode constants (EXC_*)
  - Status/Cause bit-position constants
  - reset constants
- One sub-module, cp0_timer: prescaler, Count, Compare, TI latch, and the MTC0 override logic.

## Test plan
- Reset, then read all mapped registers -> Status 32'h0040_0000, PRId PRID_VAL, Config 32'h0000_8000, everything else 0.
- COUNT_DIV=2, MTC0 Compare=5 -> Count reaches 5 at cycle 10 after reset; TI=1 next cycle. MTC0 Compare=100 -> TI=0 next cycle.
- Exception code 12, pc 0x8000_0010, bd=1 -> EPC 0x8000_000C, Cause 0x8000_0030, EXL=1, flush_pc_o 0xBFC0_0380. A second exception (code 8) -> EPC unchanged, ExcCode 8.
- AdEL with badvaddr 0x1234_5671, then ERET -> BadVAddr 0x1234_5671; ERET flush_pc_o = EPC and EXL cleared.
- Status=32'h0000_0401, hw_int_i[0]=1 -> int_pending_o=1 after 1 cycle. Set EXL -> int_pending_o=0.
- MTC0 Count=0xFFFF_FFFF -> Count reads 0 after wrap. exc_valid_i together with eret_i -> ERET ignored, EXL=1.

Source files
------------

// File: rtl/cp0_pkg.sv
// Shared constants and field packers for the CP0 register file.
// Register numbers, ExcCodes, Status/Cause bit positions and reset values
// live here so the top, the timer and any checker agree on one definition.
package cp0_pkg;

    // CP0 register numbers (rd field of MFC0/MTC0)
    localparam logic [4:0] CP0_REG_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_REG_COUNT    = 5'd9;
    localparam logic [4:0] CP0_REG_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_REG_STATUS   = 5'd12;
    localparam logic [4:0] CP0_REG_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_REG_EPC      = 5'd14;
    localparam logic [4:0] CP0_REG_PRID     = 5'd15;
    localparam logic [4:0] CP0_REG_CONFIG   = 5'd16;

    // Exception codes
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    // Status bit positions
    localparam int unsigned STATUS_IE_BIT  = 0;
    localparam int unsigned STATUS_EXL_BIT = 1;
    localparam int unsigned STATUS_IM_LSB  = 8;
    localparam int unsigned STATUS_BEV_BIT = 22;

    // Cause bit positions
    localparam int unsigned CAUSE_EXC_LSB = 2;
    localparam int unsigned CAUSE_IP_LSB  = 8;
    localparam int unsigned CAUSE_TI_BIT  = 30;
    localparam int unsigned CAUSE_BD_BIT  = 31;

    // Reset / constant register values
    localparam logic [31:0] STATUS_RESET = 32'h0040_0000;
    localparam logic [31:0] CAUSE_RESET  = 32'h0000_0000;
    localparam logic [31:0] CONFIG_VAL   = 32'h0000_8000;

    // Assemble the architectural Status word; BEV is hard-wired to 1.
    function automatic logic [31:0] status_pack(input logic [7:0] im,
                                                input logic       exl,
                                                input logic       ie);
        logic [31:0] s;
        s = '0;
        s[STATUS_BEV_BIT]      = 1'b1;
        s[STATUS_IM_LSB +: 8]  = im;
        s[STATUS_EXL_BIT]      = exl;
        s[STATUS_IE_BIT]       = ie;
        return s;
    endfunction

    // Assemble the architectural Cause word from its live fields.
    function automatic logic [31:0] cause_pack(input logic       bd,
                                               input logic       ti,
                                               input logic [7:0] ip,
                                               input logic [4:0] exccode);
        logic [31:0] c;
        c = '0;
        c[CAUSE_BD_BIT]       = bd;
        c[CAUSE_TI_BIT]       = ti;
        c[CAUSE_IP_LSB +: 8]  = ip;
        c[CAUSE_EXC_LSB +: 5] = exccode;
        return c;
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// CP0 timer: prescaler, Count, Compare and the TI latch.
// Built only when CP0_TIMER_EN is defined; otherwise Count/Compare read 0
// and TI is tied low. MTC0 Count overrides the tick and clears the
// prescaler phase; MTC0 Compare clears TI and overrides a same-cycle match.
module cp0_timer
    import cp0_pkg::*;
#(
    parameter int unsigned COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mtc0_we_i,
    input  logic [4:0]  mtc0_addr_i,
    input  logic [31:0] mtc0_data_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        ti_o
);

`ifdef CP0_TIMER_EN
    logic        phase_q, phase_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        ti_q, ti_d;
    logic        adv_q, adv_d;    // Count was advanced by a tick on the last edge
    logic        tick;
    logic        wr_count;
    logic        wr_compare;

    // Next-state for prescaler, Count, Compare and TI
    always_comb begin
        wr_count   = mtc0_we_i && (mtc0_addr_i == CP0_REG_COUNT);
        wr_compare = mtc0_we_i && (mtc0_addr_i == CP0_REG_COMPARE);
        tick       = (COUNT_DIV == 1) ? 1'b1 : phase_q;
        phase_d    = (COUNT_DIV == 1) ? 1'b0 : ~phase_q;
        count_d    = count_q;
        adv_d      = 1'b0;
        if (wr_count) begin
            count_d = mtc0_data_i;
            phase_d = 1'b0;
        end else if (tick) begin
            count_d = count_q + 32'd1;
            adv_d   = 1'b1;
        end
        compare_d = wr_compare ? mtc0_data_i : compare_q;
        ti_d      = ti_q;
        if (wr_compare) begin
            ti_d = 1'b0;
        end else if (adv_q && (count_q == compare_q)) begin
            ti_d = 1'b1;
        end
    end

    // Timer state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q   <= 1'b0;
            count_q   <= '0;
            compare_q <= '0;
            ti_q      <= 1'b0;
            adv_q     <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            ti_q      <= ti_d;
            adv_q     <= adv_d;
        end
    end

    assign count_o   = count_q;
    assign compare_o = compare_q;
    assign ti_o      = ti_q;
`else
    logic unused_timer_inputs;
    assign unused_timer_inputs = ^{clk, rst, mtc0_we_i, mtc0_addr_i, mtc0_data_i};
    assign count_o   = '0;
    assign compare_o = '0;
    assign ti_o      = 1'b0;
`endif

endmodule

// File: rtl/cp0_unit.sv
// MIPS coprocessor 0 for the 5-stage core.
// Holds BadVAddr, Count, Compare, Status, Cause, EPC, PRId, Config; serves
// MFC0/MTC0, commits one exception or ERET per cycle and drives the flush
// and redirect PC. Optional timer is enabled by defining CP0_TIMER_EN.
// Same-cycle priority: rst > exception > ERET > MTC0, applied per field, so
// an MTC0 still lands on fields the exception/ERET does not touch.
module cp0_unit
    import cp0_pkg::*;
#(
    parameter int unsigned HW_INT_NUM = 6,
    parameter int unsigned COUNT_DIV  = 2,
    parameter logic [31:0] PRID_VAL   = 32'h004C_0102,
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mtc0_we_i,
    input  logic [4:0]            mtc0_addr_i,
    input  logic [31:0]           mtc0_data_i,
    input  logic [4:0]            mfc0_addr_i,
    output logic [31:0]           mfc0_data_o,
    input  logic [HW_INT_NUM-1:0] hw_int_i,
    input  logic                  exc_valid_i,
    input  logic [4:0]            exc_code_i,
    input  logic [31:0]           exc_pc_i,
    input  logic                  exc_bd_i,
    input  logic [31:0]           exc_badvaddr_i,
    input  logic                  eret_i,
    output logic                  flush_o,
    output logic [31:0]           flush_pc_o,
    output logic                  int_pending_o,
    output logic [31:0]           status_o,
    output logic [31:0]           cause_o,
    output logic [31:0]           epc_o
);

    logic [7:0]            im_q, im_d;
    logic                  exl_q, exl_d;
    logic                  ie_q, ie_d;
    logic                  bd_q, bd_d;
    logic [4:0]            exccode_q, exccode_d;
    logic [1:0]            ip_sw_q, ip_sw_d;
    logic [HW_INT_NUM-1:0] ip_hw_q;
    logic [31:0]           epc_q, epc_d;
    logic [31:0]           badvaddr_q, badvaddr_d;

    logic [31:0] count;
    logic [31:0] compare;
    logic        ti;
    logic [5:0]  ip_hw_ext;
    logic [7:0]  ip_all;
    logic [31:0] status_val;
    logic [31:0] cause_val;
    logic        wr_status;
    logic        wr_cause;
    logic        wr_epc;

    cp0_timer #(
        .COUNT_DIV(COUNT_DIV)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .mtc0_we_i  (mtc0_we_i),
        .mtc0_addr_i(mtc0_addr_i),
        .mtc0_data_i(mtc0_data_i),
        .count_o    (count),
        .compare_o  (compare),
        .ti_o       (ti)
    );

    // Assemble architectural Status/Cause; timer shares IP7 with hw_int_i[5]
    always_comb begin
        ip_hw_ext    = 6'(ip_hw_q);
        ip_hw_ext[5] = ip_hw_ext[5] | ti;
        ip_all       = {ip_hw_ext, ip_sw_q};
        status_val   = status_pack(im_q, exl_q, ie_q);
        cause_val    = cause_pack(bd_q, ti, ip_all, exccode_q);
    end

    // Next-state: MTC0 first, then ERET, then exception overrides
    always_comb begin
        wr_status  = mtc0_we_i && (mtc0_addr_i == CP0_REG_STATUS);
        wr_cause   = mtc0_we_i && (mtc0_addr_i == CP0_REG_CAUSE);
        wr_epc     = mtc0_we_i && (mtc0_addr_i == CP0_REG_EPC);
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        exccode_d  = exccode_q;
        ip_sw_d    = ip_sw_q;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;
        if (wr_status) begin
            im_d  = mtc0_data_i[STATUS_IM_LSB +: 8];
            exl_d = mtc0_data_i[STATUS_EXL_BIT];
            ie_d  = mtc0_data_i[STATUS_IE_BIT];
        end
        if (wr_cause) begin
            ip_sw_d = mtc0_data_i[CAUSE_IP_LSB +: 2];
        end
        if (wr_epc) begin
            epc_d = mtc0_data_i;
        end
        if (eret_i && !exc_valid_i) begin
            exl_d = 1'b0;
        end
        if (exc_valid_i) begin
            exccode_d = exc_code_i;
            exl_d     = 1'b1;
            // A nested exception keeps the original return point
            if (!exl_q) begin
                epc_d = exc_bd_i ? (exc_pc_i - 32'd4) : exc_pc_i;
                bd_d  = exc_bd_i;
            end
            if ((exc_code_i == EXC_ADEL) || (exc_code_i == EXC_ADES)) begin
                badvaddr_d = exc_badvaddr_i;
            end
        end
    end

    // CP0 register file, synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            im_q       <= STATUS_RESET[STATUS_IM_LSB +: 8];
            exl_q      <= STATUS_RESET[STATUS_EXL_BIT];
            ie_q       <= STATUS_RESET[STATUS_IE_BIT];
            bd_q       <= CAUSE_RESET[CAUSE_BD_BIT];
            exccode_q  <= CAUSE_RESET[CAUSE_EXC_LSB +: 5];
            ip_sw_q    <= CAUSE_RESET[CAUSE_IP_LSB +: 2];
            ip_hw_q    <= '0;
            epc_q      <= '0;
            badvaddr_q <= '0;
        end else begin
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            exccode_q  <= exccode_d;
            ip_sw_q    <= ip_sw_d;
            ip_hw_q    <= hw_int_i;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
        end
    end

    // MFC0 read mux; returns 0 while in reset
    always_comb begin
        mfc0_data_o = '0;
        if (!rst) begin
            case (mfc0_addr_i)
                CP0_REG_BADVADDR: mfc0_data_o = badvaddr_q;
                CP0_REG_COUNT:    mfc0_data_o = count;
                CP0_REG_COMPARE:  mfc0_data_o = compare;
                CP0_REG_STATUS:   mfc0_data_o = status_val;
                CP0_REG_CAUSE:    mfc0_data_o = cause_val;
                CP0_REG_EPC:      mfc0_data_o = epc_q;
                CP0_REG_PRID:     mfc0_data_o = PRID_VAL;
                CP0_REG_CONFIG:   mfc0_data_o = CONFIG_VAL;
                default:          mfc0_data_o = '0;
            endcase
        end
    end

    // Flush/redirect and interrupt request, combinational from current state
    always_comb begin
        flush_o       = exc_valid_i | eret_i;
        flush_pc_o    = exc_valid_i ? EXC_VECTOR : epc_q;
        int_pending_o = !rst && ie_q && !exl_q && (|(ip_all & im_q));
    end

    assign status_o = status_val;
    assign cause_o  = cause_val;
    assign epc_o    = epc_q;

endmodule

// File: tb/tb_cp0_unit.sv
// Self-checking bench for cp0_unit (default parameters). Expected values
// come from the register definitions and are queued when stimulus is driven,
// then popped when the DUT output is sampled. Adapts to CP0_TIMER_EN.
module tb_cp0_unit;
    import cp0_pkg::*;

    logic        clk;
    logic        rst;
    logic        mtc0_we_i;
    logic [4:0]  mtc0_addr_i;
    logic [31:0] mtc0_data_i;
    logic [4:0]  mfc0_addr_i;
    logic [31:0] mfc0_data_o;
    logic [5:0]  hw_int_i;
    logic        exc_valid_i;
    logic [4:0]  exc_code_i;
    logic [31:0] exc_pc_i;
    logic        exc_bd_i;
    logic [31:0] exc_badvaddr_i;
    logic        eret_i;
    logic        flush_o;
    logic [31:0] flush_pc_o;
    logic        int_pending_o;
    logic [31:0] status_o;
    logic [31:0] cause_o;
    logic [31:0] epc_o;

    int vectors;
    int miscompares;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    cp0_unit dut (
        .clk           (clk),
        .rst           (rst),
        .mtc0_we_i     (mtc0_we_i),
        .mtc0_addr_i   (mtc0_addr_i),
        .mtc0_data_i   (mtc0_data_i),
        .mfc0_addr_i   (mfc0_addr_i),
        .mfc0_data_o   (mfc0_data_o),
        .hw_int_i      (hw_int_i),
        .exc_valid_i   (exc_valid_i),
        .exc_code_i    (exc_code_i),
        .exc_pc_i      (exc_pc_i),
        .exc_bd_i      (exc_bd_i),
        .exc_badvaddr_i(exc_badvaddr_i),
        .eret_i        (eret_i),
        .flush_o       (flush_o),
        .flush_pc_o    (flush_pc_o),
        .int_pending_o (int_pending_o),
        .status_o      (status_o),
        .cause_o       (cause_o),
        .epc_o         (epc_o)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Single comparison point
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard: push expectation at drive time, pop when sampled
    task automatic sb_push(input string tag, input logic [31:0] exp);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
    endtask

    task automatic sb_pop(input logic [31:0] got);
        if (exp_q.size() == 0) begin
            check_val("sb_underflow", 32'd1, 32'd0);
        end else begin
            check_val(tag_q.pop_front(), got, exp_q.pop_front());
        end
    endtask

    // Driver tasks (all drive from the falling edge)
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        mtc0_we_i   = 1'b0;
        exc_valid_i = 1'b0;
        eret_i      = 1'b0;
        hw_int_i    = '0;
        repeat (2) step();
        rst = 1'b0;
    endtask

    task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
        mtc0_we_i   = 1'b1;
        mtc0_addr_i = addr;
        mtc0_data_i = data;
        step();
        mtc0_we_i   = 1'b0;
    endtask

    task automatic read_expect(input string tag, input logic [4:0] addr, input logic [31:0] exp);
        sb_push(tag, exp);
        mfc0_addr_i = addr;
        #1;
        sb_pop(mfc0_data_o);
    endtask

    task automatic pend_expect(input string tag, input logic exp);
        sb_push(tag, {31'd0, exp});
        #1;
        sb_pop({31'd0, int_pending_o});
    endtask

    task automatic flush_expect(input string tag, input logic f, input logic [31:0] pc);
        sb_push({tag, "_flush"}, {31'd0, f});
        sb_push({tag, "_pc"}, pc);
        #1;
        sb_pop({31'd0, flush_o});
        sb_pop(flush_pc_o);
    endtask

    task automatic exc_drive(input logic [4:0] code, input logic [31:0] pc,
                             input logic bd, input logic [31:0] bva);
        exc_valid_i    = 1'b1;
        exc_code_i     = code;
        exc_pc_i       = pc;
        exc_bd_i       = bd;
        exc_badvaddr_i = bva;
    endtask

    initial begin
        vectors        = 0;
        miscompares    = 0;
        mtc0_addr_i    = '0;
        mtc0_data_i    = '0;
        mfc0_addr_i    = '0;
        exc_code_i     = '0;
        exc_pc_i       = '0;
        exc_bd_i       = 1'b0;
        exc_badvaddr_i = '0;
        @(negedge clk);

        // Reset behaviour: outputs forced low while rst is held
        rst = 1'b1;
        mtc0_we_i = 1'b0; exc_valid_i = 1'b0; eret_i = 1'b0; hw_int_i = '0;
        step();
        read_expect("rst_mfc0_status", CP0_REG_STATUS, 32'h0);
        pend_expect("rst_pending", 1'b0);
        flush_expect("idle", 1'b0, 32'h0);
        step();
        rst = 1'b0;

        read_expect("rst_count", CP0_REG_COUNT, 32'h0);
        step();
        read_expect("rst_badvaddr", CP0_REG_BADVADDR, 32'h0);
        read_expect("rst_compare", CP0_REG_COMPARE, 32'h0);
        step();
        read_expect("rst_status", CP0_REG_STATUS, 32'h0040_0000);
        read_expect("rst_cause", CP0_REG_CAUSE, 32'h0);
        step();
        read_expect("rst_epc", CP0_REG_EPC, 32'h0);
        read_expect("rst_prid", CP0_REG_PRID, 32'h004C_0102);
        step();
        read_expect("rst_config", CP0_REG_CONFIG, 32'h0000_8000);
        read_expect("rst_unmapped", 5'd3, 32'h0);
        mtc0(5'd3, 32'hDEAD_BEEF);
        read_expect("unmapped_write", 5'd3, 32'h0);
        mtc0(CP0_REG_CONFIG, 32'h1234_0000);
        read_expect("config_ro", CP0_REG_CONFIG, 32'h0000_8000);

        // Timer: fresh reset, Compare=5 written on the first edge
        do_reset();
        mtc0(CP0_REG_COMPARE, 32'd5);
        repeat (8) step();
`ifdef CP0_TIMER_EN
        read_expect("count_edge9", CP0_REG_COUNT, 32'd4);
        step();
        read_expect("count_edge10", CP0_REG_COUNT, 32'd5);
        read_expect("ti_not_yet", CP0_REG_CAUSE, 32'h0);
        step();
        read_expect("ti_set", CP0_REG_CAUSE, 32'h4000_8000);
        mtc0(CP0_REG_COMPARE, 32'd100);
        read_expect("ti_cleared", CP0_REG_CAUSE, 32'h0);
        read_expect("compare_rd", CP0_REG_COMPARE, 32'd100);
`else
        read_expect("count_off", CP0_REG_COUNT, 32'd0);
        step();
        step();
        read_expect("ti_off", CP0_REG_CAUSE, 32'h0);
        mtc0(CP0_REG_COMPARE, 32'd100);
        read_expect("compare_off", CP0_REG_COMPARE, 32'd0);
`endif
        mtc0(CP0_REG_COMPARE, 32'hFFFF_0000);

        // Exception in a delay slot
        exc_drive(EXC_OV, 32'h8000_0010, 1'b1, 32'h0);
        flush_expect("exc_ov", 1'b1, 32'hBFC0_0380);
        step();
        exc_valid_i = 1'b0;
        read_expect("epc_bd", CP0_REG_EPC, 32'h8000_000C);
        read_expect("cause_ov", CP0_REG_CAUSE, 32'h8000_0030);
        read_expect("status_exl", CP0_REG_STATUS, 32'h0040_0002);
        sb_push("epc_mirror", 32'h8000_000C);
        sb_pop(epc_o);

        // Nested exception keeps EPC and BD
        exc_drive(EXC_SYS, 32'h9000_0000, 1'b0, 32'h0);
        step();
        exc_valid_i = 1'b0;
        read_expect("epc_nested", CP0_REG_EPC, 32'h8000_000C);
        read_expect("cause_sys", CP0_REG_CAUSE, 32'h8000_0020);

        // AdEL captures BadVAddr, then ERET returns to EPC
        exc_drive(EXC_ADEL, 32'h8000_0100, 1'b0, 32'h1234_5671);
        step();
        exc_valid_i = 1'b0;
        read_expect("badvaddr", CP0_REG_BADVADDR, 32'h1234_5671);
        read_expect("cause_adel", CP0_REG_CAUSE, 32'h8000_0010);
        eret_i = 1'b1;
        flush_expect("eret", 1'b1, 32'h8000_000C);
        step();
        eret_i = 1'b0;
        read_expect("status_eret", CP0_REG_STATUS, 32'h0040_0000);
        flush_expect("idle2", 1'b0, 32'h8000_000C);

        // Interrupts: IM2 + IE, hw_int_i[0]
        mtc0(CP0_REG_STATUS, 32'h0000_0401);
        read_expect("status_im", CP0_REG_STATUS, 32'h0040_0401);
        sb_push("status_mirror", 32'h0040_0401);
        sb_pop(status_o);
        hw_int_i = 6'b000001;
        pend_expect("pend_before", 1'b0);
        step();
        pend_expect("pend_after", 1'b1);
        read_expect("cause_ip2", CP0_REG_CAUSE, 32'h8000_0410);
        mtc0(CP0_REG_STATUS, 32'h0000_0403);
        pend_expect("pend_exl", 1'b0);
        mtc0(CP0_REG_STATUS, 32'h0000_0401);
        pend_expect("pend_again", 1'b1);

        // Count wrap
        mtc0(CP0_REG_COUNT, 32'hFFFF_FFFF);
`ifdef CP0_TIMER_EN
        read_expect("count_written", CP0_REG_COUNT, 32'hFFFF_FFFF);
        step();
        read_expect("count_hold", CP0_REG_COUNT, 32'hFFFF_FFFF);
        step();
        read_expect("count_wrap", CP0_REG_COUNT, 32'h0);
`else
        read_expect("count_wr_off", CP0_REG_COUNT, 32'h0);
`endif

        // Exception + ERET + MTC0 Cause in one cycle: ERET ignored, IP[1:0] written
        exc_drive(EXC_BP, 32'h8000_0200, 1'b0, 32'h0);
        eret_i      = 1'b1;
        mtc0_we_i   = 1'b1;
        mtc0_addr_i = CP0_REG_CAUSE;
        mtc0_data_i = 32'h0000_0300;
        flush_expect("exc_eret", 1'b1, 32'hBFC0_0380);
        step();
        exc_valid_i = 1'b0;
        eret_i      = 1'b0;
        mtc0_we_i   = 1'b0;
        read_expect("status_eret_ign", CP0_REG_STATUS, 32'h0040_0403);
        read_expect("epc_bp", CP0_REG_EPC, 32'h8000_0200);
        read_expect("cause_bp", CP0_REG_CAUSE, 32'h0000_0724);
        step();
        pend_expect("pend_bp_exl", 1'b0);
        eret_i = 1'b1;
        flush_expect("eret2", 1'b1, 32'h8000_0200);
        step();
        eret_i = 1'b0;
        pend_expect("pend_after_eret", 1'b1);

        if (exp_q.size() != 0) begin
            check_val("sb_leftover", exp_q.size(), 32'd0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
